gate_vector_checker: RTL and testbench

Synthesizable response-checking stimulus engine for 2-input basic logic gates. On a start request it drives all four input vectors {a,b} = 00, 01, 10, 11 into a gate under test. It holds each vector for a programmable settle time, samples the gate output, and compares it against a parameterised truth table. It reports pass/fail, the mismatch count and the first failing vector, so gate checks run on-chip or on FPGA rather than only in simulation.

---
 rtl/gate_chk_pkg.sv | 26 ++
 rtl/gate_vector_checker_settle_timer.sv | 33 +++
 rtl/gate_vector_checker.sv | 105 ++++++++++
 tb/tb_gate_vector_checker.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate vector checker.
// Truth tables: bit i is the expected y for {a,b} = i.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  localparam int NUM_VECTORS = 4;

  function automatic int cnt_width(input int s);
    int w;
    w = $clog2(s + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/gate_vector_checker_settle_timer.sv
// Settle counter: expire pulses in the last cycle
// of each SETTLE_CYCLES-long window while enabled.
module settle_timer
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = cnt_width(SETTLE_CYCLES);
  localparam logic [CW-1:0] LAST =
    CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign expire = enable && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (expire) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/gate_vector_checker.sv
// Drives all four {a,b} vectors into a 2-input gate,
// samples its output after a settle time, checks a truth table.
module gate_vector_checker
  import gate_chk_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE   = 4'b0001,
  parameter int         SETTLE_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic       fail_valid,
  output logic [1:0] first_fail_vec
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $fatal(1, "SETTLE_CYCLES must be in 1..255");
  end

  localparam logic [1:0] LAST_VEC = 2'(NUM_VECTORS - 1);

  state_t     state;
  logic [1:0] vec;
  logic       expire;
  logic       mismatch;

  assign mismatch = (y_in != TRUTH_TABLE[vec]);

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state != RUN),
    .enable(state == RUN),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      vec            <= '0;
      a_out          <= 1'b0;
      b_out          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state          <= RUN;
            vec            <= '0;
            {a_out, b_out} <= 2'b00;
            busy           <= 1'b1;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
          end
        end
        RUN: begin
          if (expire) begin
            if (mismatch) begin
              err_count <= err_count + 3'd1;
              if (!fail_valid) begin
                fail_valid     <= 1'b1;
                first_fail_vec <= vec;
              end
            end
            // pass must include this final sample
            if (vec == LAST_VEC) begin
              state          <= DONE;
              busy           <= 1'b0;
              done           <= 1'b1;
              {a_out, b_out} <= 2'b00;
              pass <= (err_count == 3'd0) && !mismatch;
            end else begin
              vec            <= vec + 2'd1;
              {a_out, b_out} <= vec + 2'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench: NOR checker at S=10 against several
// gate models, plus an S=1 instance with start held high.
module tb_gate_vector_checker;
  import gate_chk_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic       y_in;
  logic       a_out;
  logic       b_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic       fail_valid;
  logic [1:0] first_fail_vec;

  logic       start1;
  logic       y1_in;
  logic       a1_out;
  logic       b1_out;
  logic       busy1;
  logic       done1;
  logic       pass1;
  logic [2:0] err1;
  logic       fv1;
  logic [1:0] ffv1;

  int mode;
  int n_vec = 0;
  int n_bad = 0;

  gate_vector_checker #(
    .TRUTH_TABLE  (TT_NOR),
    .SETTLE_CYCLES(10)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .y_in          (y_in),
    .a_out         (a_out),
    .b_out         (b_out),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .fail_valid    (fail_valid),
    .first_fail_vec(first_fail_vec)
  );

  gate_vector_checker #(
    .TRUTH_TABLE  (TT_NOR),
    .SETTLE_CYCLES(1)
  ) dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start1),
    .y_in          (y1_in),
    .a_out         (a1_out),
    .b_out         (b1_out),
    .busy          (busy1),
    .done          (done1),
    .pass          (pass1),
    .err_count     (err1),
    .fail_valid    (fv1),
    .first_fail_vec(ffv1)
  );

  // 0: NOR, 1: OR, 2: stuck-at-0, 3: stuck-at-1
  always_comb begin
    case (mode)
      0:       y_in = ~(a_out | b_out);
      1:       y_in = a_out | b_out;
      2:       y_in = 1'b0;
      default: y_in = 1'b1;
    endcase
  end

  assign y1_in = 1'b0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic do_run(
    input string      tag,
    input int         extra_k,
    input logic [2:0] e_err,
    input logic       e_fv,
    input logic [1:0] e_ffv,
    input logic       e_pass
  );
    int         done_k;
    int         done_n;
    logic [7:0] seq_first;
    logic [7:0] seq_last;
    logic [2:0] done_out;
    done_k    = 0;
    done_n    = 0;
    seq_first = '0;
    seq_last  = '0;
    done_out  = 3'b111;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      start = (k == extra_k);
      case (k)
        1, 11, 21, 31:
          seq_first = {seq_first[5:0], a_out, b_out};
        10, 20, 30, 40:
          seq_last = {seq_last[5:0], a_out, b_out};
        default: ;
      endcase
      if (done) begin
        done_n++;
        if (done_k == 0) begin
          done_k   = k;
          done_out = {busy, a_out, b_out};
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, ".done_at"}, 32'(done_k), 32'd41);
    check({tag, ".done_n"}, 32'(done_n), 32'd1);
    check({tag, ".seq_first"}, 32'(seq_first), 32'h1b);
    check({tag, ".seq_last"}, 32'(seq_last), 32'h1b);
    check({tag, ".done_out"}, 32'(done_out), 32'd0);
    check({tag, ".err"}, 32'(err_count), 32'(e_err));
    check({tag, ".fv"}, 32'(fail_valid), 32'(e_fv));
    check({tag, ".ffv"}, 32'(first_fail_vec), 32'(e_ffv));
    check({tag, ".pass"}, 32'(pass), 32'(e_pass));
  endtask

  initial begin
    int         d_n;
    int         d_k [3];
    int         busy_n;
    logic [7:0] seq1;
    rst_n  = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    mode   = 0;
    repeat (2) @(negedge clk);
    check("rst.ctl",
          32'({a_out, b_out, busy, done, pass}), 32'd0);
    check("rst.res",
          32'({err_count, fail_valid, first_fail_vec}), 32'd0);
    check("rst.ctl1",
          32'({a1_out, b1_out, busy1, done1, pass1}), 32'd0);
    rst_n = 1'b1;

    mode = 0;
    do_run("nor", -1, 3'd0, 1'b0, 2'b00, 1'b1);
    mode = 1;
    do_run("or", -1, 3'd4, 1'b1, 2'b00, 1'b0);
    mode = 2;
    do_run("stk0", -1, 3'd1, 1'b1, 2'b00, 1'b0);
    mode = 3;
    do_run("stk1", -1, 3'd3, 1'b1, 2'b01, 1'b0);
    mode = 0;
    do_run("restart", 15, 3'd0, 1'b0, 2'b00, 1'b1);

    // reset in the middle of vector 2
    mode = 2;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (24) @(negedge clk);
    check("mid.err_pre", 32'(err_count), 32'd1);
    check("mid.vec", 32'({a_out, b_out}), 32'd2);
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    check("mid.ctl",
          32'({a_out, b_out, busy, done}), 32'd0);
    check("mid.res",
          32'({err_count, fail_valid}), 32'd0);
    d_n = 0;
    for (int k = 0; k < 50; k++) begin
      if (done) d_n++;
      @(negedge clk);
    end
    check("mid.no_done", 32'(d_n), 32'd0);
    mode = 0;
    do_run("post_rst", -1, 3'd0, 1'b0, 2'b00, 1'b1);

    // S=1 with start held high
    d_n    = 0;
    busy_n = 0;
    seq1   = '0;
    d_k    = '{0, 0, 0};
    @(negedge clk) start1 = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (busy1) busy_n++;
      if (k <= 4) seq1 = {seq1[5:0], a1_out, b1_out};
      if (k == 7) check("s1.clr", 32'(err1), 32'd0);
      if (done1) begin
        if (d_n < 3) d_k[d_n] = k;
        d_n++;
      end
      if (k == 11) begin
        check("s1.err", 32'(err1), 32'd1);
        check("s1.pass", 32'(pass1), 32'd0);
        check("s1.fail",
              32'({fv1, ffv1}), 32'({1'b1, 2'b00}));
      end
    end
    start1 = 1'b0;
    check("s1.seq", 32'(seq1), 32'h1b);
    check("s1.busy_n", 32'(busy_n), 32'd12);
    check("s1.done_n", 32'(d_n), 32'd3);
    check("s1.done0", 32'(d_k[0]), 32'd5);
    check("s1.done1", 32'(d_k[1]), 32'd11);
    check("s1.done2", 32'(d_k[2]), 32'd17);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
